pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. It replaces the hand-written per-stage registers (if/id, id/ex, ex/mem, mem/wb).
- Carries an arbitrary-width payload plus a valid bit.
- Indexes its own slot in the global stall vector and supports flush, hold and bubble insertion.
- Adds saturating per-stage performance counters and a hold-timeout watchdog for debug.

Parameters:
- DATA_W, 64, payload width in bits (e.g. pc+inst = 64).
- STALL_W, 6, width of the global stall vector.
- STAGE, 1, index of this register's upstream stage in the stall vector; legal range 0..STALL_W-1.
- CNT_W, 32, width of each performance counter.
- HOLD_MAX, 1024, consecutive-hold cycle limit before timeout; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high (1 = RstEnable).
- stall  in  STALL_W  global stall vector; 1 = Stop.
- flush  in  1  discard contents (exception/branch redirect).
- in_data  in  DATA_W  payload from upstream stage.
- in_valid  in  1  upstream payload is a real instruction.
- clr_cnt  in  1  synchronous clear of the counters and the timeout flag.
- out_data  out  DATA_W  registered payload to downstream stage.
- out_valid  out  1  registered valid.
- bubble_cnt  out  CNT_W  cycles in which a bubble was inserted.
- hold_cnt  out  CNT_W  cycles in which the register held its contents.
- flush_cnt  out  CNT_W  cycles in which a flush was applied.
- hold_timeout  out  1  sticky flag: hold lasted more than HOLD_MAX consecutive cycles.

Behaviour:
- Definitions:
  - up_stop = stall[STAGE].
  - dn_stop = stall[STAGE+1], or 0 (NoStop) when STAGE = STALL_W-1.
- Per rising edge, first matching rule wins:
  1. rst=1: out_data=0, out_valid=0, all counters=0, hold_timeout=0, run-length counter=0.
  2. flush=1: out_data=0, out_valid=0, flush_cnt+1. Flush overrides any stall.
  3. up_stop=1, dn_stop=0 (bubble): out_data=0, out_valid=0, bubble_cnt+1.
  4. up_stop=1, dn_stop=1 (hold): out_data and out_valid unchanged, hold_cnt+1.
  5. Otherwise (load): out_data=in_data, out_valid=in_valid. Loading occurs even when dn_stop=1 alone; the caller guarantees a monotonic stall vector.
- Latency: one cycle, in_* to out_*. No combinational path from inputs to outputs.
- Counters:
  - Each counter saturates at all-ones and never wraps.
  - clr_cnt=1 zeroes bubble_cnt, hold_cnt, flush_cnt and hold_timeout. It wins over a same-cycle increment but loses to rst.
  - clr_cnt does not affect out_data or out_valid.
- Hold watchdog:
  - Internal run-length counter counts consecutive rule-4 cycles. Width is clog2(HOLD_MAX+1), saturating.
  - The counter resets to 0 on any cycle not taken by rule 4, including flush cycles.
  - hold_timeout sets on the cycle the run length reaches HOLD_MAX+1, then stays sticky until rst or clr_cnt.
  - HOLD_MAX=0: hold_timeout is tied to 0.
- Reset mid-hold: rst drops the held payload immediately. The next non-reset cycle follows the normal rules.
- Elaboration check: fatal error if STAGE >= STALL_W.

Decomposition:
- Shared package:
  - stall-vector width constant.
  - Stop/NoStop and RstEnable/RstDisable constants.
  - ZeroWord.
  - stage-index constants (PC=0, IF=1, ID=2, EX=3, MEM=4, WB=5).
- One natural sub-module: sat_counter (parameter W; ports clk, rst, clr, inc, q). It is instantiated three times, plus once for the run-length counter.
- The stage-action decode (load/hold/bubble/flush) is an inline combinational block; it is not a separate module.

Test Plan:
- Reset then load: rst=1 for 2 cycles → out_data=0, out_valid=0, all counters 0. Release, stall=0, in_data=0x0000_0040_2402_0005, in_valid=1 → next cycle out_data=0x0000_0040_2402_0005, out_valid=1.
- Bubble vs hold (STAGE=1):
  - stall=6'b000010 → out_valid=0, out_data=0, bubble_cnt=1.
  - stall=6'b000110 for 3 cycles → payload unchanged, hold_cnt=3.
- Flush priority: stall=6'b000110 with flush=1 → out_valid=0, flush_cnt=1, hold_cnt unchanged, run-length reset.
- Watchdog: HOLD_MAX=4, hold for 5 cycles → hold_timeout=1 at the end of the 5th hold. Release stall → flag stays 1. clr_cnt=1 → flag and all counters 0.
- Saturation/clear race: CNT_W=3, 9 bubble cycles → bubble_cnt=7. Bubble with clr_cnt=1 in the same cycle → bubble_cnt=0.
- Last stage: STAGE=5, stall=6'b100000 → bubble inserted (dn_stop treated as 0), bubble_cnt+1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the inter-stage pipeline registers.
package pipe_stage_reg_pkg;

    localparam int STALL_WIDTH = 6;

    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;
    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Slot indices of each stage in the global stall vector
    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } stageAction_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, payload and debug-counter signals around one pipeline register.
interface pipe_stage_reg_if #(
    parameter int DATA_W  = 64,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               clr_cnt;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic [CNT_W-1:0]   bubble_cnt;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic               hold_timeout;

    modport master (
        output stall, flush, in_data, in_valid, clr_cnt,
        input  out_data, out_valid, bubble_cnt, hold_cnt, flush_cnt, hold_timeout
    );

    modport slave (
        input  stall, flush, in_data, in_valid, clr_cnt,
        output out_data, out_valid, bubble_cnt, hold_cnt, flush_cnt, hold_timeout
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign q = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with flush/hold/bubble control, debug counters and hold watchdog.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int STALL_W  = STALL_WIDTH,
    parameter int STAGE    = STAGE_IF,
    parameter int CNT_W    = 32,
    parameter int HOLD_MAX = 1024
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus
);

    generate
        if (STAGE < 0 || STAGE >= STALL_W) begin : g_badStage
            $fatal(1, "pipe_stage_reg: STAGE must lie in 0..STALL_W-1");
        end
    endgenerate

    logic         w_upStop;
    logic         w_dnStop;
    stageAction_e w_action;
    logic         w_isHold;
    logic [DATA_W-1:0] r_outData;
    logic              r_outValid;

    assign w_upStop = bus.stall[STAGE];

    // The last stage has nobody downstream, so it never sees a downstream stop
    generate
        if (STAGE == STALL_W - 1) begin : g_lastStage
            assign w_dnStop = NoStop;
        end else begin : g_midStage
            assign w_dnStop = bus.stall[STAGE+1];
        end
    endgenerate

    always_comb begin
        w_action = ACT_LOAD;
        if (bus.flush) begin
            w_action = ACT_FLUSH;
        end else if ((w_upStop == Stop) && (w_dnStop == NoStop)) begin
            w_action = ACT_BUBBLE;
        end else if (w_upStop == Stop) begin
            w_action = ACT_HOLD;
        end
    end

    assign w_isHold = (w_action == ACT_HOLD);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else begin
            case (w_action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_outData  <= '0;
                    r_outValid <= 1'b0;
                end
                ACT_HOLD: begin
                    r_outData  <= r_outData;
                    r_outValid <= r_outValid;
                end
                default: begin
                    r_outData  <= bus.in_data;
                    r_outValid <= bus.in_valid;
                end
            endcase
        end
    end

    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;

    sat_counter #(.W(CNT_W)) u_bubbleCnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr_cnt),
        .inc (w_action == ACT_BUBBLE),
        .q   (bus.bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_holdCnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr_cnt),
        .inc (w_isHold),
        .q   (bus.hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr_cnt),
        .inc (w_action == ACT_FLUSH),
        .q   (bus.flush_cnt)
    );

    // The flag fires on the hold cycle that pushes the run past HOLD_MAX
    generate
        if (HOLD_MAX > 0) begin : g_watchdog
            localparam int RUN_W = $clog2(HOLD_MAX + 1);

            logic [RUN_W-1:0] w_runLen;
            logic             r_holdTimeout;

            sat_counter #(.W(RUN_W)) u_runLen (
                .clk (clk),
                .rst (rst),
                .clr (!w_isHold),
                .inc (w_isHold),
                .q   (w_runLen)
            );

            always_ff @(posedge clk) begin
                if (rst == RstEnable) begin
                    r_holdTimeout <= 1'b0;
                end else if (bus.clr_cnt) begin
                    r_holdTimeout <= 1'b0;
                end else if (w_isHold && (w_runLen == RUN_W'(HOLD_MAX))) begin
                    r_holdTimeout <= 1'b1;
                end
            end

            assign bus.hold_timeout = r_holdTimeout;
        end else begin : g_noWatchdog
            assign bus.hold_timeout = 1'b0;
        end
    endgenerate

endmodule
